mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM. Serves instruction fetches from the IF stage and loads and stores from the MEM stage. Issues the per-stage stall requests that the stall controller turns into the 6-bit stall vector consumed by the pipeline registers. One RAM transaction is in flight at a time; each 32-bit access is split into byte beats.

## Interface
Parameters:
- ADDR_W, 32, byte address width; RAM address wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  IF stage wants a 32-bit instruction word
- if_addr  in  32  fetch address
- if_data  out  32  fetched word, valid when if_done
- if_done  out  1  one-cycle fetch-complete pulse
- mem_req  in  1  MEM stage load/store request
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  byte address
- mem_len  in  3  byte count: 1, 2 or 4; any other value is treated as 4
- mem_wdata  in  32  store data, little-endian, low bytes used
- mem_rdata  out  32  load data, zero-extended, valid when mem_done
- mem_done  out  1  one-cycle load/store-complete pulse
- branch_flush  in  1  EX stage taken branch/jump
- stall_req_if  out  1  to stall controller
- stall_req_mem  out  1  to stall controller
- ram_din  in  8  RAM read data, one cycle after ram_a
- ram_dout  out  8  RAM write data
- ram_a  out  32  RAM byte address
- ram_wr  out  1  RAM write enable

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR. A beat counter idx (0..4) tracks progress.
- IDLE:
  - mem_req has priority over if_req. When both are high, MEM is accepted and IF waits.
  - Accept cycle T: latch address, len and wdata; set idx=0; ram_a <= addr; move to MEM_RD, MEM_WR or IF_RD.
- Read states:
  - Each cycle, ram_a <= base+idx+1 until n addresses have been issued.
  - The byte on ram_din is placed into buffer lane idx-1, little-endian.
  - After n bytes are captured: pulse done, drive if_data or mem_rdata with the buffer (upper lanes 0), return to IDLE.
- MEM_WR:
  - Beat k drives ram_a=base+k, ram_dout=byte k, ram_wr=1.
  - After n beats: ram_wr=0, pulse mem_done, return to IDLE.
- Address arithmetic is base+idx in ADDR_W bits and wraps from 0xFFFFFFFF to 0.
- Stall requests (combinational):
  - stall_req_if = if_req & ~if_done
  - stall_req_mem = mem_req & ~mem_done
  - Both are 0 during rst.
- Requesters drop req in the cycle after done. The controller ignores req in the done cycle; a new accept happens at the earliest the cycle after done.
- branch_flush while idle or during a MEM transaction has no effect.

## Timing
- Reset values: state IDLE, idx 0, ram_a 0, ram_dout 0, ram_wr 0, if_data 0, mem_rdata 0, if_done 0, mem_done 0.
- Read of n bytes accepted at cycle T: done high at T+n+1. A 4-byte fetch or load takes 5 cycles from request to done.
- Write of n bytes: beats at T+1..T+n, done at T+n. A 1-byte store completes at T+1.
- Data outputs hold their value until the next done of the same port.
- Reset mid-operation: next edge returns to IDLE with ram_wr=0. A partially written word stays partially written.

## Configuration
- MEM_CTRL_IF_ABORT_EN defined:
  - branch_flush in IF_RD moves to IDLE at the next edge.
  - if_done is not pulsed, and if_done is suppressed if the flush coincides with the final beat.
  - A pending mem_req may be accepted the cycle after the abort.
- Undefined: branch_flush is ignored. The fetch completes and if_done pulses normally; the IF stage discards the word.

## Structure
- Shared defines header: FSM state encodings, Enable/Disable, ZeroWord, stall-vector bit indices.
- One sub-module: mem_ctrl_beat (beat counter plus byte-lane assemble/split). It is instantiated once and shared by read and write paths.

## Test plan
- Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> if_done at T+5, if_data=0x00000513, stall_req_if high T..T+4.
- Byte and halfword loads from 0x2001: RAM 0x2001=0x80, 0x2002=0x7F.
  - mem_len=1 -> mem_rdata=0x00000080 at T+2.
  - mem_len=2 -> mem_rdata=0x00007F80 at T+3.
- Store word: mem_we=1, addr=0x3000, wdata=0xDEADBEEF -> ram_wr high T+1..T+4 writing EF,BE,AD,DE to 0x3000..0x3003, mem_done at T+4.
- Both if_req and mem_req in IDLE -> MEM is served first; the IF fetch is accepted the cycle after mem_done and if_done follows 5 cycles later.
- Fetch at 0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 0, 1.
- branch_flush at T+2 of a fetch:
  - With MEM_CTRL_IF_ABORT_EN: IDLE at T+3, no if_done.
  - Without it: if_done at T+5.
- rst asserted at T+2 of a store: ram_wr=0 from T+3 and all outputs at reset values.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// FSM states, enable levels, the zero word and stall-vector bit indices.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Bit positions in the 6-bit stall vector built by the stall controller
    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    function automatic logic [2:0] len_bytes(input logic [2:0] len);
        return (len == 3'd1 || len == 3'd2) ? len : 3'd4;
    endfunction

endpackage

// File: rtl/mem_ctrl_beat.sv
// Beat counter plus byte-lane buffer, shared by the read and write paths:
// reads merge RAM bytes into lanes, writes pick the next byte out of the word.
module mem_ctrl_beat
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic        clr,
    input  logic        inc,
    input  logic        cap,
    input  logic [31:0] ld_data,
    input  logic [7:0]  din,
    output logic [2:0]  idx,
    output logic [31:0] word,
    output logic [7:0]  nxt_byte
);

    logic [31:0] word_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= 3'd0;
            word_q <= ZERO_WORD;
        end else if (ld) begin
            idx    <= 3'd0;
            word_q <= ld_data;
        end else begin
            if (clr)
                idx <= 3'd0;
            else if (inc)
                idx <= idx + 3'd1;
            if (cap)
                word_q <= word;
        end
    end

    // The byte on din belongs to the address issued one beat earlier
    always_comb begin
        word = word_q;
        case (idx)
            3'd1:    word[7:0]   = din;
            3'd2:    word[15:8]  = din;
            3'd3:    word[23:16] = din;
            3'd4:    word[31:24] = din;
            default: ;
        endcase
    end

    always_comb begin
        nxt_byte = 8'h00;
        case (idx)
            3'd0:    nxt_byte = word_q[15:8];
            3'd1:    nxt_byte = word_q[23:16];
            3'd2:    nxt_byte = word_q[31:24];
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial controller between IF/MEM stages and the 8-bit unified RAM.
// Define MEM_CTRL_IF_ABORT_EN to let branch_flush abort an in-flight fetch.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic              branch_flush,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_t state, state_nx;

    logic [ADDR_W-1:0] base, ld_addr;
    logic [2:0]        len, ld_len, idx;
    logic [31:0]       ld_data, word, if_hold, mem_hold;
    logic [7:0]        nxt_byte;
    logic              ld, ld_wr, inc, cap, clr, fin;

    mem_ctrl_beat u_beat (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .clr      (clr),
        .inc      (inc),
        .cap      (cap),
        .ld_data  (ld_data),
        .din      (ram_din),
        .idx      (idx),
        .word     (word),
        .nxt_byte (nxt_byte)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld       = DISABLE;
        ld_wr    = DISABLE;
        ld_addr  = ADDR_W'(if_addr);
        ld_len   = 3'd4;
        ld_data  = ZERO_WORD;
        inc      = DISABLE;
        cap      = DISABLE;
        fin      = DISABLE;
        unique case (state)
            IDLE: begin
                if (mem_req) begin
                    ld       = ENABLE;
                    ld_wr    = mem_we;
                    ld_addr  = ADDR_W'(mem_addr);
                    ld_len   = len_bytes(mem_len);
                    ld_data  = mem_we ? mem_wdata : ZERO_WORD;
                    state_nx = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req) begin
                    ld       = ENABLE;
                    state_nx = IF_RD;
                end
            end
            IF_RD, MEM_RD: begin
                cap = (idx != 3'd0);
                if (idx == len) begin
                    fin      = ENABLE;
                    state_nx = IDLE;
                end else begin
                    inc = ENABLE;
                end
`ifdef MEM_CTRL_IF_ABORT_EN
                if (state == IF_RD && branch_flush) begin
                    fin      = DISABLE;
                    inc      = DISABLE;
                    state_nx = IDLE;
                end
`endif
            end
            MEM_WR: begin
                if (idx == len - 3'd1) begin
                    fin      = ENABLE;
                    state_nx = IDLE;
                end else begin
                    inc = ENABLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifndef MEM_CTRL_IF_ABORT_EN
    logic unused_flush;
    assign unused_flush = branch_flush;
`endif

    assign clr = (state_nx == IDLE) & ~ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            len      <= 3'd0;
            ram_a    <= '0;
            ram_dout <= 8'h00;
            ram_wr   <= DISABLE;
            if_hold  <= ZERO_WORD;
            mem_hold <= ZERO_WORD;
        end else begin
            if (ld) begin
                base     <= ld_addr;
                len      <= ld_len;
                ram_a    <= ld_addr;
                ram_dout <= ld_data[7:0];
                ram_wr   <= ld_wr;
            end else if (fin && state == MEM_WR) begin
                ram_wr <= DISABLE;
            end else if (inc && (state == MEM_WR || idx + 3'd1 < len)) begin
                ram_a    <= base + ADDR_W'(idx) + ADDR_W'(1);
                ram_dout <= nxt_byte;
            end
            if (if_done)
                if_hold <= word;
            if (mem_done && state == MEM_RD)
                mem_hold <= word;
        end
    end

    // Final byte arrives in the done cycle, so data bypasses the hold register
    assign if_done   = fin & (state == IF_RD) & ~rst;
    assign mem_done  = fin & (state != IF_RD) & ~rst;
    assign if_data   = if_done ? word : if_hold;
    assign mem_rdata = (mem_done && state == MEM_RD) ? word : mem_hold;

    assign stall_req_if  = if_req & ~if_done & ~rst;
    assign stall_req_mem = mem_req & ~mem_done & ~rst;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected completions
// and RAM write beats; a negedge monitor pops and compares them.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_data;
    logic        if_done;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [2:0]  mem_len = 3'd0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        branch_flush = 1'b0;
    logic        stall_req_if;
    logic        stall_req_mem;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_data       (if_data),
        .if_done       (if_done),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_len       (mem_len),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_done      (mem_done),
        .branch_flush  (branch_flush),
        .stall_req_if  (stall_req_if),
        .stall_req_mem (stall_req_mem),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_a         (ram_a),
        .ram_wr        (ram_wr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        ram_din <= ram[ram_a[15:0]];
        if (ram_wr === 1'b1)
            ram[ram_a[15:0]] <= ram_dout;
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    exp_t if_q[$];
    exp_t mem_q[$];
    wr_t  wr_q[$];

    int vectors = 0;
    int errors  = 0;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (if_done === 1'b1) begin
            if (if_q.size() == 0) begin
                check("if_done_extra", 32'(if_done), 32'd0);
            end else begin
                e = if_q.pop_front();
                check("if_data", if_data, e.data);
                check("if_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_done === 1'b1) begin
            if (mem_q.size() == 0) begin
                check("mem_done_extra", 32'(mem_done), 32'd0);
            end else begin
                e = mem_q.pop_front();
                if (e.chk)
                    check("mem_rdata", mem_rdata, e.data);
                check("mem_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_extra", 32'(ram_wr), 32'd0);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", ram_a, w.addr);
                check("wr_data", 32'(ram_dout), 32'(w.data));
                check("wr_cyc", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_if);
        int n = 0;
        forever begin
            @(negedge clk);
            if (is_if ? if_done : mem_done) break;
            n++;
            if (n > 30) begin
                check(is_if ? "if_timeout" : "mem_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input int n,
                           input logic [31:0] wdata, input int t);
        for (int k = 0; k < n; k++)
            wr_q.push_back('{addr + 32'(k), wdata[8*k +: 8], t + 1 + k});
    endtask

    task automatic mem_op(input bit we, input logic [31:0] addr,
                          input logic [2:0] len, input logic [31:0] wdata,
                          input logic [31:0] exp);
        int t, n;
        tick();
        mem_req = 1'b1;
        mem_we = we;
        mem_addr = addr;
        mem_len = len;
        mem_wdata = wdata;
        t = cyc;
        n = (len == 3'd1 || len == 3'd2) ? int'(len) : 4;
        if (we) begin
            push_wr(addr, n, wdata, t);
            mem_q.push_back('{32'h0, t + n, 1'b0});
        end else begin
            mem_q.push_back('{exp, t + n + 1, 1'b1});
        end
        wait_done(1'b0);
        tick();
        mem_req = 1'b0;
        mem_we = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13;
        ram[16'h0101] = 8'h05;
        ram[16'h2001] = 8'h80;
        ram[16'h2002] = 8'h7F;
        ram[16'hFFFE] = 8'h11;
        ram[16'hFFFF] = 8'h22;
        ram[16'h0000] = 8'h33;
        ram[16'h0001] = 8'h44;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ram_a", ram_a, 32'h0);
        check("rst_ram_wr", 32'(ram_wr), 32'h0);
        check("rst_ram_dout", 32'(ram_dout), 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_done", 32'({if_done, mem_done}), 32'h0);

        tick();
        if_req = 1'b1;
        if_addr = 32'h100;
        t = cyc;
        if_q.push_back('{32'h0000_0513, t + 5, 1'b1});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_if", 32'(stall_req_if), 32'(i < 5));
        end
        tick();
        if_req = 1'b0;

        mem_op(1'b0, 32'h2001, 3'd1, 32'h0, 32'h0000_0080);
        mem_op(1'b0, 32'h2001, 3'd2, 32'h0, 32'h0000_7F80);
        mem_op(1'b0, 32'h0100, 3'd3, 32'h0, 32'h0000_0513);
        mem_op(1'b1, 32'h3000, 3'd4, 32'hDEAD_BEEF, 32'h0);
        mem_op(1'b0, 32'h3000, 3'd4, 32'h0, 32'hDEAD_BEEF);
        mem_op(1'b1, 32'h3300, 3'd1, 32'h1234_5678, 32'h0);
        mem_op(1'b0, 32'h3300, 3'd2, 32'h0, 32'h0000_0078);
        mem_op(1'b1, 32'h3400, 3'd2, 32'hAABB_CCDD, 32'h0);
        mem_op(1'b0, 32'h3400, 3'd4, 32'h0, 32'h0000_CCDD);

        tick();
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h3100;
        mem_len = 3'd4;
        mem_wdata = 32'h0102_0304;
        if_req = 1'b1;
        if_addr = 32'h100;
        t = cyc;
        push_wr(32'h3100, 4, 32'h0102_0304, t);
        mem_q.push_back('{32'h0, t + 4, 1'b0});
        if_q.push_back('{32'h0000_0513, t + 10, 1'b1});
        wait_done(1'b0);
        tick();
        mem_req = 1'b0;
        mem_we = 1'b0;
        wait_done(1'b1);
        tick();
        if_req = 1'b0;

        tick();
        if_req = 1'b1;
        if_addr = 32'hFFFF_FFFE;
        t = cyc;
        if_q.push_back('{32'h4433_2211, t + 5, 1'b1});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 4)
                check("wrap_ram_a", ram_a, 32'hFFFF_FFFE + 32'(i - 1));
        end
        tick();
        if_req = 1'b0;

        tick();
        if_req = 1'b1;
        if_addr = 32'h100;
        t = cyc;
`ifdef MEM_CTRL_IF_ABORT_EN
        tick();
        tick();
        branch_flush = 1'b1;
        @(negedge clk);
        check("flush_no_done", 32'(if_done), 32'h0);
        tick();
        branch_flush = 1'b0;
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_done", 32'(if_done), 32'h0);
            tick();
        end
`else
        if_q.push_back('{32'h0000_0513, t + 5, 1'b1});
        tick();
        tick();
        branch_flush = 1'b1;
        tick();
        branch_flush = 1'b0;
        wait_done(1'b1);
        tick();
        if_req = 1'b0;
`endif

        tick();
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h3200;
        mem_len = 3'd4;
        mem_wdata = 32'hCAFE_F00D;
        t = cyc;
        push_wr(32'h3200, 2, 32'hCAFE_F00D, t);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_stall_mem", 32'(stall_req_mem), 32'h0);
        tick();
        rst = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        @(negedge clk);
        check("mid_rst_ram_wr", 32'(ram_wr), 32'h0);
        check("mid_rst_ram_a", ram_a, 32'h0);
        check("mid_rst_ram_dout", 32'(ram_dout), 32'h0);
        check("mid_rst_if_data", if_data, 32'h0);
        check("mid_rst_mem_rdata", mem_rdata, 32'h0);
        check("mid_rst_done", 32'({if_done, mem_done}), 32'h0);
        mem_op(1'b0, 32'h3200, 3'd4, 32'h0, 32'h0000_F00D);

        repeat (3) tick();
        check("if_q_left", 32'(if_q.size()), 32'h0);
        check("mem_q_left", 32'(mem_q.size()), 32'h0);
        check("wr_q_left", 32'(wr_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
